// File: rtl/pulse_width_meter.sv
// Measures the width of an asynchronous input pulse in clk_i cycles, rejecting
// glitches, flagging overlong pulses and ignoring new pulses during a holdoff window.
module pulse_width_meter #(
    parameter int MAX_WIDTH = 100,
    parameter int MIN_WIDTH = 2,
    parameter int HOLDOFF   = 4,
    localparam int W        = $clog2(MAX_WIDTH + 1)
) (
    input  logic         clk_i,
    input  logic         rst,
    input  logic         pulse_i,
    output logic         strobe_o,
    output logic [W-1:0] width_o,
    output logic         glitch_o,
    output logic         ovf_o,
    output logic         busy_o
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [W-1:0]  MAX_CNT   = W'(MAX_WIDTH);
    localparam logic [W-1:0]  MIN_CNT   = W'(MIN_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        WAIT_LOW,
        HOLD_OFF
    } state_t;

    // With no holdoff the meter re-arms immediately after a pulse ends.
    localparam state_t AFTER_PULSE = (HOLDOFF == 0) ? IDLE : HOLD_OFF;
    localparam logic   BUSY_AFTER  = (HOLDOFF != 0);

    logic          sync1_q;
    logic          sync2_q;
    logic          pinDly_q;
    logic          pinS;
    logic          rise;
    state_t        state_q;
    logic [W-1:0]  cnt_q;
    logic [HW-1:0] hcnt_q;
    logic          strobe_q;
    logic          glitch_q;
    logic          ovf_q;
    logic          busy_q;
    logic [W-1:0]  width_q;

    // Synchronizer and edge history deliberately stay out of reset, so a level
    // held high across reset is never mistaken for a fresh rising edge.
    always_ff @(posedge clk_i) begin
        sync1_q  <= pulse_i;
        sync2_q  <= sync1_q;
        pinDly_q <= sync2_q;
    end

    assign pinS = sync2_q;
    assign rise = pinS & ~pinDly_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            strobe_q <= 1'b0;
            glitch_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            width_q  <= '0;
        end else begin
            strobe_q <= 1'b0;
            glitch_q <= 1'b0;
            ovf_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_q   <= W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (pinS) begin
                        // Saturate at MAX_WIDTH and report overflow instead of wrapping.
                        if (cnt_q == MAX_CNT) begin
                            ovf_q   <= 1'b1;
                            state_q <= WAIT_LOW;
                        end else begin
                            cnt_q <= cnt_q + W'(1);
                        end
                    end else begin
                        if (cnt_q >= MIN_CNT) begin
                            strobe_q <= 1'b1;
                            width_q  <= cnt_q;
                        end else begin
                            glitch_q <= 1'b1;
                        end
                        state_q <= AFTER_PULSE;
                        hcnt_q  <= HOLD_LOAD;
                        busy_q  <= BUSY_AFTER;
                    end
                end
                WAIT_LOW: begin
                    if (!pinS) begin
                        state_q <= AFTER_PULSE;
                        hcnt_q  <= HOLD_LOAD;
                        busy_q  <= BUSY_AFTER;
                    end
                end
                HOLD_OFF: begin
                    if (hcnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_q - HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign strobe_o = strobe_q;
    assign width_o  = width_q;
    assign glitch_o = glitch_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter: directed scenarios and random pulse
// trains compared against a pulse-level reference model.
module tb_pulse_width_meter;

    localparam int MAX_WIDTH = 100;
    localparam int MIN_WIDTH = 2;
    localparam int HOLDOFF   = 4;
    localparam int W         = $clog2(MAX_WIDTH + 1);

    logic         clk_i   = 1'b0;
    logic         rst     = 1'b1;
    logic         pulse_i = 1'b0;
    logic         strobe_o;
    logic         glitch_o;
    logic         ovf_o;
    logic         busy_o;
    logic [W-1:0] width_o;

    int checks     = 0;
    int errors     = 0;
    int modelWidth = 0;

    // Samples are packed as {busy, ovf, glitch, strobe, width}.
    bit           stim[$];
    logic [W+3:0] obs[$];
    logic [W+3:0] expSamples[$];

    pulse_width_meter #(
        .MAX_WIDTH(MAX_WIDTH),
        .MIN_WIDTH(MIN_WIDTH),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk_i   (clk_i),
        .rst     (rst),
        .pulse_i (pulse_i),
        .strobe_o(strobe_o),
        .width_o (width_o),
        .glitch_o(glitch_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic startStim();
        stim.delete();
        repeat (3) stim.push_back(1'b0);
    endtask

    task automatic addPulse(input int len, input int gap);
        repeat (len) stim.push_back(1'b1);
        repeat (gap) stim.push_back(1'b0);
    endtask

    // Drives stim[j] after relative edge j; obs[t-1] holds outputs after edge t.
    task automatic runStim();
        obs.delete();
        foreach (stim[j]) begin
            pulse_i = stim[j];
            @(posedge clk_i);
            #1;
            obs.push_back({busy_o, ovf_o, glitch_o, strobe_o, width_o});
        end
    endtask

    // A pulse of length L driven from index a is seen when the meter is idle by
    // edge a+2; its verdict lands at edge a+L+3 (overflow at a+MAX+3) and the
    // meter re-arms HOLDOFF edges after the verdict.
    task automatic buildExpected();
        int n;
        int j;
        int readyEdge;
        bit strobeE[];
        bit glitchE[];
        bit ovfE[];
        bit busyE[];
        int widthE[];
        n         = stim.size();
        strobeE   = new[n + 1];
        glitchE   = new[n + 1];
        ovfE      = new[n + 1];
        busyE     = new[n + 1];
        widthE    = new[n + 1];
        foreach (widthE[t]) widthE[t] = modelWidth;
        j         = 0;
        readyEdge = 0;
        while (j < n) begin
            if (stim[j] == 1'b1) begin
                int a;
                int len;
                int e;
                a   = j;
                len = 0;
                while (j < n && stim[j] == 1'b1) begin
                    len++;
                    j++;
                end
                if (a + 2 >= readyEdge) begin
                    e = a + len + 3;
                    if (len > MAX_WIDTH) begin
                        if (a + MAX_WIDTH + 3 <= n) ovfE[a + MAX_WIDTH + 3] = 1'b1;
                    end else if (len >= MIN_WIDTH) begin
                        if (e <= n) strobeE[e] = 1'b1;
                        for (int t = e; t <= n; t++) widthE[t] = len;
                        modelWidth = len;
                    end else if (e <= n) begin
                        glitchE[e] = 1'b1;
                    end
                    for (int t = a + 3; t < e + HOLDOFF && t <= n; t++) busyE[t] = 1'b1;
                    readyEdge = e + HOLDOFF;
                end
            end else begin
                j++;
            end
        end
        expSamples.delete();
        for (int t = 0; t <= n; t++)
            expSamples.push_back({busyE[t], ovfE[t], glitchE[t], strobeE[t], W'(widthE[t])});
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        pulse_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (strobe_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b want 0", strobe_o); end
        checks++;
        if (glitch_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_glitch: got %b want 0", glitch_o); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
        checks++;
        if (width_o !== '0) begin errors++; $display("[TB] FAIL reset_width: got %0d want 0", width_o); end
        pulse_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if ({busy_o, strobe_o, glitch_o, ovf_o} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL held_high_no_rise cycle %0d: got {busy,strobe,glitch,ovf}=%b want 0000",
                         i, {busy_o, strobe_o, glitch_o, ovf_o});
            end
        end
        pulse_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic();
        logic [W+3:0] s;
        int nStrobe;
        int nGlitch;
        int nOvf;
        startStim();
        addPulse(10, 12);
        addPulse(1, 12);
        addPulse(2, 12);
        addPulse(100, 12);
        addPulse(150, 12);
        runStim();
        buildExpected();
        for (int t = 1; t <= stim.size(); t++) begin
            checks++;
            if (obs[t-1] !== expSamples[t]) begin
                errors++;
                $display("[TB] FAIL basic edge %0d: got {busy,ovf,glitch,strobe,width}=%b want %b",
                         t, obs[t-1], expSamples[t]);
            end
        end
        s = obs[15];
        checks++;
        if (s[W] !== 1'b1 || s[W-1:0] !== W'(10)) begin
            errors++;
            $display("[TB] FAIL first_strobe_latency: got strobe=%b width=%0d want strobe=1 width=10", s[W], s[W-1:0]);
        end
        s = obs[18];
        checks++;
        if (s[W+3] !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_holdoff: got %b want 1", s[W+3]); end
        s = obs[19];
        checks++;
        if (s[W+3] !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_holdoff: got %b want 0", s[W+3]); end
        nStrobe = 0;
        nGlitch = 0;
        nOvf    = 0;
        foreach (obs[k]) begin
            s = obs[k];
            nStrobe += int'(s[W]);
            nGlitch += int'(s[W+1]);
            nOvf    += int'(s[W+2]);
        end
        checks++;
        if (nStrobe != 3 || nGlitch != 1 || nOvf != 1) begin
            errors++;
            $display("[TB] FAIL basic_event_counts: got strobe/glitch/ovf=%0d/%0d/%0d want 3/1/1", nStrobe, nGlitch, nOvf);
        end
        checks++;
        if (width_o !== W'(100)) begin errors++; $display("[TB] FAIL width_after_ovf: got %0d want 100", width_o); end
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] s;
        int nStrobe;
        int nOther;
        startStim();
        addPulse(10, 3);
        addPulse(10, 12);
        addPulse(10, 9);
        addPulse(10, 12);
        addPulse(10, 4);
        addPulse(10, 12);
        addPulse(10, 5);
        addPulse(10, 12);
        runStim();
        buildExpected();
        for (int t = 1; t <= stim.size(); t++) begin
            checks++;
            if (obs[t-1] !== expSamples[t]) begin
                errors++;
                $display("[TB] FAIL back_to_back edge %0d: got {busy,ovf,glitch,strobe,width}=%b want %b",
                         t, obs[t-1], expSamples[t]);
            end
        end
        nStrobe = 0;
        nOther  = 0;
        foreach (obs[k]) begin
            s = obs[k];
            nStrobe += int'(s[W]);
            nOther  += int'(s[W+1]) + int'(s[W+2]);
        end
        checks++;
        if (nStrobe != 6 || nOther != 0) begin
            errors++;
            $display("[TB] FAIL holdoff_counts: got strobes=%0d other=%0d want 6/0", nStrobe, nOther);
        end
    endtask

    task automatic test_random();
        startStim();
        for (int p = 0; p < 30; p++) begin
            int len;
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       len = $urandom_range(1, 3);
                1:       len = $urandom_range(98, 103);
                default: len = $urandom_range(1, 150);
            endcase
            addPulse(len, $urandom_range(1, 14));
        end
        repeat (12) stim.push_back(1'b0);
        runStim();
        buildExpected();
        for (int t = 1; t <= stim.size(); t++) begin
            checks++;
            if (obs[t-1] !== expSamples[t]) begin
                errors++;
                $display("[TB] FAIL random edge %0d: got {busy,ovf,glitch,strobe,width}=%b want %b",
                         t, obs[t-1], expSamples[t]);
            end
        end
    endtask

    task automatic test_reset_midpulse();
        pulse_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL busy_before_abort: got %b want 1", busy_o); end
        rst = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, strobe_o, glitch_o, ovf_o} !== 4'b0 || width_o !== '0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got {busy,strobe,glitch,ovf}=%b width=%0d want 0000 width=0",
                     {busy_o, strobe_o, glitch_o, ovf_o}, width_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 14) pulse_i = 1'b0;
            @(posedge clk_i);
            #1;
            checks++;
            if ({busy_o, strobe_o, glitch_o, ovf_o} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL abort_remainder cycle %0d: got {busy,strobe,glitch,ovf}=%b want 0000",
                         i, {busy_o, strobe_o, glitch_o, ovf_o});
            end
        end
        modelWidth = 0;
        startStim();
        addPulse(8, 12);
        runStim();
        buildExpected();
        for (int t = 1; t <= stim.size(); t++) begin
            checks++;
            if (obs[t-1] !== expSamples[t]) begin
                errors++;
                $display("[TB] FAIL after_abort edge %0d: got {busy,ovf,glitch,strobe,width}=%b want %b",
                         t, obs[t-1], expSamples[t]);
            end
        end
        checks++;
        if (width_o !== W'(8)) begin errors++; $display("[TB] FAIL width_after_abort: got %0d want 8", width_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_reset_midpulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
